filter_read_addr_gen: RTL and testbench

- Downstream consumer of the current-filter start address.
- Walks the filter scratchpad from the latched start address, one read address per beat, under a valid/ready handshake to the filter SRAM read port.
- Replays the filter `reuse_count` times, once per output window.
- Then issues a registered `next_filter` pulse that advances the start-address stage to the following filter.

---
 rtl/filter_read_addr_gen.sv | 116 +++++++++++
 tb/tb_filter_read_addr_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_read_addr_gen.sv
// Filter scratchpad read-address walker: replays one filter reuse_count times
// under a valid/ready handshake, then pulses next_filter to advance the start-address stage.
module filter_read_addr_gen #(
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_FILTER_SIZE = 4,
    parameter int REUSE_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      filter_start_addr,
    input  logic [MAX_FILTER_SIZE-1:0] filter_size,
    input  logic                       interleaved_mode,
    input  logic                       lane_sel,
    input  logic [REUSE_WIDTH-1:0]     reuse_count,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_last,
    output logic                       next_filter,
    output logic                       busy,
    output logic                       done
);

    localparam logic [MAX_FILTER_SIZE-1:0] SZ_ONE = MAX_FILTER_SIZE'(1);
    localparam logic [REUSE_WIDTH-1:0]     RU_ONE = REUSE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, NEXT} state_t;

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      pass_base;
    logic [MAX_FILTER_SIZE-1:0] size_q;
    logic [MAX_FILTER_SIZE-1:0] elem;
    logic [REUSE_WIDTH-1:0]     reuse_q;
    logic [REUSE_WIDTH-1:0]     pass;
    logic                       stride2;
    logic [ADDR_WIDTH-1:0]      step;
    logic [ADDR_WIDTH-1:0]      first_addr;

    assign step       = stride2 ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
    assign first_addr = filter_start_addr + ADDR_WIDTH'(interleaved_mode & lane_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pass_base   <= '0;
            size_q      <= '0;
            elem        <= '0;
            reuse_q     <= '0;
            pass        <= '0;
            stride2     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            rd_last     <= 1'b0;
            next_filter <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    next_filter <= 1'b0;
                    if (start) begin
                        if (filter_size != '0 && reuse_count != '0) begin
                            // lane offset is folded into the pass base so each replay restarts there
                            pass_base <= first_addr;
                            size_q    <= filter_size;
                            reuse_q   <= reuse_count;
                            stride2   <= interleaved_mode;
                            elem      <= '0;
                            pass      <= '0;
                            rd_valid  <= 1'b1;
                            rd_addr   <= first_addr;
                            rd_last   <= (filter_size == SZ_ONE);
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            elem <= '0;
                            if (pass == reuse_q - RU_ONE) begin
                                // rd_addr keeps the final address while idle
                                rd_valid    <= 1'b0;
                                rd_last     <= 1'b0;
                                next_filter <= 1'b1;
                                done        <= 1'b1;
                                state       <= NEXT;
                            end else begin
                                pass    <= pass + RU_ONE;
                                rd_addr <= pass_base;
                                rd_last <= (size_q == SZ_ONE);
                            end
                        end else begin
                            elem    <= elem + SZ_ONE;
                            rd_addr <= rd_addr + step;
                            rd_last <= (elem + SZ_ONE == size_q - SZ_ONE);
                        end
                    end
                end
                NEXT: begin
                    next_filter <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_read_addr_gen.sv
// Randomized self-checking bench for filter_read_addr_gen; expected address streams
// come from a plain nested-loop model of the filter walk.
module tb_filter_read_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] filter_start_addr = '0;
    logic [3:0]  filter_size = '0;
    logic        interleaved_mode = 1'b0;
    logic        lane_sel = 1'b0;
    logic [7:0]  reuse_count = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic        rd_last;
    logic        next_filter;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    filter_read_addr_gen #(
        .ADDR_WIDTH(16), .MAX_FILTER_SIZE(4), .REUSE_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .filter_start_addr(filter_start_addr), .filter_size(filter_size),
        .interleaved_mode(interleaved_mode), .lane_sel(lane_sel),
        .reuse_count(reuse_count), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_last(rd_last),
        .next_filter(next_filter), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: rd_ready always 1; mode 1: random rd_ready; mode 2: fixed pattern 1,0,0,1,1 then 1
    task automatic test_request(input logic [15:0] b, input logic [3:0] sz, input logic il,
                                input logic ls, input logic [7:0] ru, input int mode,
                                input bit inject);
        logic [15:0] exp_addr[$];
        bit          exp_last[$];
        bit          pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          s, hs, nf, dn, busy_cyc, k;
        bit          hold, got_done;
        logic [15:0] prev_addr, ea;
        bit          el;
        s = int'(sz) * int'(ru);
        hs = 0; nf = 0; dn = 0; busy_cyc = 0; k = 0; hold = 0; got_done = 0; prev_addr = '0;
        for (int p = 0; p < int'(ru); p++)
            for (int e = 0; e < int'(sz); e++) begin
                exp_addr.push_back(16'(int'(b) + e * (il ? 2 : 1) + ((il && ls) ? 1 : 0)));
                exp_last.push_back(e == int'(sz) - 1);
            end
        filter_start_addr = b; filter_size = sz; interleaved_mode = il; lane_sel = ls;
        reuse_count = ru; rd_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        filter_start_addr = 16'($urandom); filter_size = 4'($urandom);
        interleaved_mode = 1'($urandom); lane_sel = 1'($urandom); reuse_count = 8'($urandom);
        while (!got_done && k < 2000) begin
            k++;
            if (busy) busy_cyc++;
            if (next_filter) nf++;
            if (done) got_done = 1;
            if (done) dn++;
            if (hold) begin
                checks++;
                if (rd_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL addr_hold: got %h expected %h", rd_addr, prev_addr);
                end
            end
            checks++;
            if (!rd_valid && rd_last) begin
                errors++;
                $display("FAIL last_unqualified: got rd_last=1 expected 0 with rd_valid=0");
            end
            if (got_done) break;
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = 1'($urandom);
                default: rd_ready = (k <= 5) ? pat[k-1] : 1'b1;
            endcase
            start = (inject && rd_valid) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            if (rd_valid && rd_ready) begin
                hs++;
                ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : 16'hxxxx;
                el = (exp_last.size() != 0) ? exp_last.pop_front() : 1'b0;
                checks++;
                if (rd_addr !== ea || rd_last !== el) begin
                    errors++;
                    $display("FAIL beat%0d: got addr %h last %b expected addr %h last %b",
                             hs, rd_addr, rd_last, ea, el);
                end
            end
            hold = rd_valid && !rd_ready;
            prev_addr = rd_addr;
            tick();
        end
        start = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL timeout: got no done within %0d cycles expected done", k);
        end
        checks++;
        if (hs !== s) begin
            errors++;
            $display("FAIL beat_count: got %0d expected %0d", hs, s);
        end
        checks++;
        if (nf !== ((s != 0) ? 1 : 0) || dn !== 1) begin
            errors++;
            $display("FAIL pulses: got next_filter %0d done %0d expected %0d and 1",
                     nf, dn, (s != 0) ? 1 : 0);
        end
        checks++;
        if (busy_cyc !== ((s != 0) ? k : 0)) begin
            errors++;
            $display("FAIL busy_cycles: got %0d expected %0d", busy_cyc, (s != 0) ? k : 0);
        end
        if (mode == 0) begin
            checks++;
            if (k !== s + 1) begin
                errors++;
                $display("FAIL latency: got done at cycle %0d expected %0d", k, s + 1);
            end
        end
        tick();
        checks++;
        if ({rd_valid, next_filter, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL back_idle: got v/nf/busy/done %b expected 0000",
                     {rd_valid, next_filter, busy, done});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({rd_valid, rd_addr, rd_last, next_filter, busy, done} !== 21'b0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {rd_valid, rd_addr, rd_last, next_filter, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        test_request(16'h0010, 4'd3, 1'b0, 1'b0, 8'd1, 0, 1'b0);
    endtask

    task automatic test_interleaved();
        test_request(16'h0020, 4'd4, 1'b1, 1'b1, 8'd2, 0, 1'b0);
        test_request(16'h0040, 4'd3, 1'b1, 1'b0, 8'd1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        test_request(16'h0300, 4'd2, 1'b0, 1'b0, 8'd1, 2, 1'b0);
    endtask

    task automatic test_wrap();
        test_request(16'hFFFE, 4'd4, 1'b0, 1'b0, 8'd1, 0, 1'b0);
        test_request(16'hFFFD, 4'd3, 1'b1, 1'b1, 8'd1, 0, 1'b0);
    endtask

    task automatic test_degenerate();
        test_request(16'h0050, 4'd0, 1'b0, 1'b0, 8'd3, 0, 1'b0);
        test_request(16'h0050, 4'd5, 1'b0, 1'b0, 8'd0, 0, 1'b0);
        test_request(16'h0060, 4'd1, 1'b0, 1'b0, 8'd3, 0, 1'b0);
    endtask

    task automatic test_mid_start();
        test_request(16'h0123, 4'd6, 1'b1, 1'b0, 8'd2, 1, 1'b1);
    endtask

    task automatic test_mid_reset();
        int beats = 0;
        int guard = 0;
        filter_start_addr = 16'h0100; filter_size = 4'd5; interleaved_mode = 1'b0;
        lane_sel = 1'b0; reuse_count = 8'd1; rd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (beats < 2 && guard < 20) begin
            guard++;
            if (rd_valid) beats++;
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_addr, rd_last, next_filter, busy, done} !== 21'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0",
                     {rd_valid, rd_addr, rd_last, next_filter, busy, done});
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({next_filter, busy, rd_valid} !== 3'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got nf/busy/v %b expected 000",
                         {next_filter, busy, rd_valid});
            end
        end
        test_request(16'h0100, 4'd5, 1'b0, 1'b0, 8'd1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            test_request(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                         8'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleaved();
        test_backpressure();
        test_wrap();
        test_degenerate();
        test_mid_start();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
